datapath: RTL and testbench

//  Single-cycle 32-bit RV32I-subset processor core: PC, instruction ROM, 32x32 register file,
//  ALU, branch unit, 512-word data memory. Top-level compute block of the FPGA build.
//  A 5-bit switch input is memory-mapped for loads. A debug read port exposes data memory,
//  and the writeback value is exported.

---
 rtl/datapath_if.sv | 21 ++
 rtl/datapath.sv | 165 ++++++++++++++++
 tb/tb_datapath.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Board-facing signals of the core: switch input, debug data-memory read port and writeback export.
interface datapath_if;
   logic [4:0]  swval;
   logic [8:0]  extmemaddress;
   logic [31:0] extmemdata;
   logic [31:0] rdval;

   modport master (
      output swval,
      output extmemaddress,
      input  extmemdata,
      input  rdval
   );

   modport slave (
      input  swval,
      input  extmemaddress,
      output extmemdata,
      output rdval
   );
endinterface

// File: rtl/datapath.sv
// Single-cycle RV32I-subset core: PC, instruction ROM, register file, ALU, branch unit, data memory.
// One instruction per clock; rdval and extmemdata are combinational, all state commits at posedge.
module datapath #(
   parameter int    IMEM_DEPTH = 256,
   parameter string IMEM_FILE  = "program.hex",
   parameter int    DMEM_DEPTH = 512
) (
   input logic       clk,
   input logic       reset,
   datapath_if.slave bus
);
   localparam int IW = $clog2(IMEM_DEPTH);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_t;

   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] dmem [DMEM_DEPTH];
   logic [31:0] rf   [32];

   logic [31:0]   pc, pc_plus4, next_pc, instr;
   logic [IW-1:0] fetch_idx;
   logic [6:0]    opcode, funct7;
   logic [4:0]    rd, rs1, rs2;
   logic [2:0]    funct3;
   logic [31:0]   imm_i, imm_s, imm_b, imm_j;
   logic [31:0]   rs1_val, rs2_val, alu_b, alu_res, load_val, wb_val;
   logic [8:0]    mem_idx;
   logic          mmio, taken;

   logic    reg_write, mem_write, mem_read, use_imm, is_branch, is_jal;
   alu_op_t alu_op;

   assign pc_plus4  = pc + 32'd4;
   assign fetch_idx = IW'({24'd0, pc[9:2]} % IMEM_DEPTH);
   assign instr     = imem[fetch_idx];

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

   always_comb begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      use_imm   = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      alu_op    = ALU_ADD;
      case (opcode)
         OP_R: begin
            reg_write = 1'b1;
            case ({funct7, funct3})
               {7'h00, 3'b000}: alu_op = ALU_ADD;
               {7'h20, 3'b000}: alu_op = ALU_SUB;
               {7'h00, 3'b001}: alu_op = ALU_SLL;
               {7'h00, 3'b010}: alu_op = ALU_SLT;
               {7'h00, 3'b100}: alu_op = ALU_XOR;
               {7'h00, 3'b101}: alu_op = ALU_SRL;
               {7'h00, 3'b110}: alu_op = ALU_OR;
               {7'h00, 3'b111}: alu_op = ALU_AND;
               default:         reg_write = 1'b0;
            endcase
         end
         OP_I: begin
            use_imm   = 1'b1;
            reg_write = 1'b1;
            case (funct3)
               3'b000:  alu_op = ALU_ADD;
               3'b010:  alu_op = ALU_SLT;
               3'b100:  alu_op = ALU_XOR;
               3'b110:  alu_op = ALU_OR;
               3'b111:  alu_op = ALU_AND;
               default: reg_write = 1'b0;
            endcase
         end
         OP_LW: begin
            if (funct3 == 3'b010) begin
               use_imm   = 1'b1;
               mem_read  = 1'b1;
               reg_write = 1'b1;
            end
         end
         OP_SW: begin
            if (funct3 == 3'b010) begin
               use_imm   = 1'b1;
               mem_write = 1'b1;
            end
         end
         OP_BR:   is_branch = (funct3 == 3'b000) || (funct3 == 3'b001);
         OP_JAL: begin
            is_jal    = 1'b1;
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   // Stores take the S-format immediate; every other immediate user takes the I-format one.
   assign alu_b = !use_imm ? rs2_val : (mem_write ? imm_s : imm_i);

   always_comb begin
      alu_res = rs1_val + alu_b;
      case (alu_op)
         ALU_ADD: alu_res = rs1_val + alu_b;
         ALU_SUB: alu_res = rs1_val - alu_b;
         ALU_AND: alu_res = rs1_val & alu_b;
         ALU_OR:  alu_res = rs1_val | alu_b;
         ALU_XOR: alu_res = rs1_val ^ alu_b;
         ALU_SLT: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
         ALU_SLL: alu_res = rs1_val << alu_b[4:0];
         ALU_SRL: alu_res = rs1_val >> alu_b[4:0];
         default: alu_res = rs1_val + alu_b;
      endcase
   end

   assign taken   = is_branch && ((rs1_val == rs2_val) ^ funct3[0]);
   assign next_pc = is_jal ? (pc + imm_j) : (taken ? (pc + imm_b) : pc_plus4);

   // EA bit 11 selects the switch window; bits [10:2] index the word array.
   assign mmio     = alu_res[11];
   assign mem_idx  = alu_res[10:2];
   assign load_val = mmio ? {27'd0, bus.swval} : dmem[mem_idx];
   assign wb_val   = mem_read ? load_val : (is_jal ? pc_plus4 : alu_res);

   assign bus.rdval      = (reg_write && !reset) ? wb_val : 32'd0;
   assign bus.extmemdata = dmem[bus.extmemaddress];

   always_ff @(posedge clk) begin
      if (reset) pc <= 32'd0;
      else       pc <= next_pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (reg_write && (rd != 5'd0)) begin
         rf[rd] <= wb_val;
      end
   end

   // Data memory has no reset so its contents survive a core reset.
   always_ff @(posedge clk) begin
      if (!reset && mem_write && !mmio) dmem[mem_idx] <= rs2_val;
   end
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed ISA scenarios plus random programs checked against an
// instruction-level reference model of the architectural state.
module tb_datapath;
   logic clk   = 1'b0;
   logic reset = 1'b1;

   datapath_if bus();

   datapath #(.IMEM_DEPTH(256), .IMEM_FILE(""), .DMEM_DEPTH(512)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] prog  [256];
   logic [31:0] m_reg [32];
   logic [31:0] m_mem [512];
   logic [31:0] m_pc;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
      return {f7, r2, r1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {im, r1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, input logic [4:0] r1);
      return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [2:0] f3,
                                         input logic [4:0] r1, input logic [4:0] r2);
      return {off[12], off[10:5], r2, r1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rd, r1, r2;
      logic [11:0] im;
      int          k, s, o;
      rd = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      im = 12'($urandom);
      s  = int'($urandom_range(0, 5));
      o  = (s < 2) ? (s - 2) * 4 : (s - 1) * 4;
      k  = int'($urandom_range(0, 21));
      case (k)
         0:  return enc_r(7'h00, 3'b000, rd, r1, r2);
         1:  return enc_r(7'h20, 3'b000, rd, r1, r2);
         2:  return enc_r(7'h00, 3'b111, rd, r1, r2);
         3:  return enc_r(7'h00, 3'b110, rd, r1, r2);
         4:  return enc_r(7'h00, 3'b100, rd, r1, r2);
         5:  return enc_r(7'h00, 3'b010, rd, r1, r2);
         6:  return enc_r(7'h00, 3'b001, rd, r1, r2);
         7:  return enc_r(7'h00, 3'b101, rd, r1, r2);
         8, 9: return enc_i(im, r1, 3'b000, rd, 7'b0010011);
         10: return enc_i(im, r1, 3'b111, rd, 7'b0010011);
         11: return enc_i(im, r1, 3'b110, rd, 7'b0010011);
         12: return enc_i(im, r1, 3'b100, rd, 7'b0010011);
         13: return enc_i(im, r1, 3'b010, rd, 7'b0010011);
         14, 15: return enc_i(im, r1, 3'b010, rd, 7'b0000011);
         16, 17: return enc_s(im, r2, r1);
         18: return enc_b(13'(o), 3'b000, r1, r2);
         19: return enc_b(13'(o), 3'b001, r1, r2);
         20: return enc_j(21'(o), rd);
         default: return {25'($urandom), 7'b0110111};
      endcase
   endfunction

   // Architectural model: executes the instruction at m_pc, updates state, returns expected rdval.
   task automatic model_step(output logic [31:0] rdv);
      logic [31:0] ins, a, b, imm, res, ea, npc;
      logic [6:0]  op, f7;
      logic [4:0]  rd;
      logic [2:0]  f3;
      bit          we;
      ins = prog[8'(m_pc >> 2)];
      op  = ins[6:0];
      rd  = ins[11:7];
      f3  = ins[14:12];
      f7  = ins[31:25];
      a   = m_reg[ins[19:15]];
      b   = m_reg[ins[24:20]];
      we  = 1'b0;
      res = 32'd0;
      npc = m_pc + 32'd4;
      imm = 32'($signed(ins) >>> 20);
      case (op)
         7'h33: begin
            we = 1'b1;
            if      (f7 == 7'h00 && f3 == 3'd0) res = a + b;
            else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
            else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
            else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
            else if (f7 == 7'h00 && f3 == 3'd4) res = a ^ b;
            else if (f7 == 7'h00 && f3 == 3'd2) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else if (f7 == 7'h00 && f3 == 3'd1) res = a << b[4:0];
            else if (f7 == 7'h00 && f3 == 3'd5) res = a >> b[4:0];
            else we = 1'b0;
         end
         7'h13: begin
            we = 1'b1;
            if      (f3 == 3'd0) res = a + imm;
            else if (f3 == 3'd2) res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            else if (f3 == 3'd4) res = a ^ imm;
            else if (f3 == 3'd6) res = a | imm;
            else if (f3 == 3'd7) res = a & imm;
            else we = 1'b0;
         end
         7'h03: if (f3 == 3'd2) begin
            we  = 1'b1;
            ea  = a + imm;
            res = ea[11] ? 32'(bus.swval) : m_mem[ea[10:2]];
         end
         7'h23: if (f3 == 3'd2) begin
            imm = (imm & 32'hFFFF_FFE0) | 32'(ins[11:7]);
            ea  = a + imm;
            if (!ea[11]) m_mem[ea[10:2]] = b;
         end
         7'h63: if (f3 == 3'd0 || f3 == 3'd1) begin
            imm = (ins[31] ? 32'hFFFF_F000 : 32'h0) + (ins[7] ? 32'd2048 : 32'd0)
                + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2;
            if ((a == b) != f3[0]) npc = m_pc + imm;
         end
         7'h6F: begin
            imm = (ins[31] ? 32'hFFF0_0000 : 32'h0) + 32'(ins[19:12]) * 32'd4096
                + (ins[20] ? 32'd2048 : 32'd0) + 32'(ins[30:21]) * 32'd2;
            we  = 1'b1;
            res = m_pc + 32'd4;
            npc = m_pc + imm;
         end
         default: ;
      endcase
      if (we && rd != 5'd0) m_reg[rd] = res;
      rdv  = we ? res : 32'd0;
      m_pc = npc;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
   endtask

   task automatic apply_reset(input int ncyc);
      @(negedge clk);
      reset = 1'b1;
      repeat (ncyc) @(negedge clk);
      reset = 1'b0;
      m_pc  = 32'd0;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 256; i++) prog[i] = rand_instr();
      load_prog();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         bus.extmemaddress = 9'($urandom);
         #1;
         n_vec++;
         if (bus.rdval !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rdval[%0d]: got %h, want 00000000", c, bus.rdval);
         end
         n_vec++;
         if (bus.extmemdata !== m_mem[bus.extmemaddress]) begin
            n_err++;
            $display("FAIL reset_dmem[%0d]: got %h, want %h", c, bus.extmemdata, m_mem[bus.extmemaddress]);
         end
         @(negedge clk);
      end
      reset = 1'b0;
      m_pc  = 32'd0;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      #1;
      n_vec++;
      if (dut.pc !== 32'd0) begin
         n_err++;
         $display("FAIL reset_pc: got %h, want 00000000", dut.pc);
      end
      for (int i = 0; i < 32; i++) begin
         n_vec++;
         if (dut.rf[i] !== 32'd0) begin
            n_err++;
            $display("FAIL reset_reg x%0d: got %h, want 00000000", i, dut.rf[i]);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] exp_rd [15];
      logic [31:0] exp_pc [15];
      logic [31:0] rdv, want;
      exp_rd = '{32'd5, 32'd7, 32'd12, 32'd10, 32'd0, 32'd0, 32'd0, 32'd36, 32'd9, 32'd0,
                 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd64, 32'd11};
      exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd28, 32'd32, 32'd40, 32'd44,
                 32'd48, 32'd52, 32'd56, 32'd60, 32'd12};
      for (int i = 0; i < 256; i++) prog[i] = 32'd0;
      prog[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
      prog[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);
      prog[2]  = enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
      prog[3]  = enc_i(12'h800, 5'd0, 3'b010, 5'd4, 7'b0000011);
      prog[4]  = enc_s(12'd256, 5'd3, 5'd0);
      prog[5]  = enc_b(13'd8, 3'b000, 5'd1, 5'd1);
      prog[6]  = enc_i(12'd99, 5'd0, 3'b000, 5'd6, 7'b0010011);
      prog[7]  = enc_b(13'd8, 3'b001, 5'd1, 5'd1);
      prog[8]  = enc_j(21'd8, 5'd5);
      prog[9]  = enc_i(12'd77, 5'd0, 3'b000, 5'd6, 7'b0010011);
      prog[10] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);
      prog[11] = enc_r(7'h00, 3'b000, 5'd7, 5'd0, 5'd0);
      prog[12] = enc_i(12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011);
      prog[13] = enc_r(7'h20, 3'b000, 5'd8, 5'd0, 5'd9);
      prog[14] = enc_r(7'h00, 3'b010, 5'd10, 5'd8, 5'd9);
      prog[15] = enc_j(21'(-48), 5'd0);
      load_prog();
      dut.dmem[64] <= 32'hA5A5_0000;
      m_mem[64]     = 32'hA5A5_0000;
      apply_reset(2);
      for (int i = 0; i < 15; i++) begin
         bus.swval = (i < 14) ? 5'd10 : 5'd11;
         if (i == 4 || i == 5)  bus.extmemaddress = 9'd64;
         else if (i == 6)       bus.extmemaddress = 9'd63;
         else                   bus.extmemaddress = 9'($urandom);
         if (i == 4)      want = 32'hA5A5_0000;
         else if (i == 5) want = 32'd12;
         else             want = m_mem[bus.extmemaddress];
         #1;
         n_vec++;
         if (dut.pc !== exp_pc[i]) begin
            n_err++;
            $display("FAIL dir_pc[%0d]: got %h, want %h", i, dut.pc, exp_pc[i]);
         end
         n_vec++;
         if (bus.extmemdata !== want) begin
            n_err++;
            $display("FAIL dir_dmem[%0d] addr %0d: got %h, want %h", i, bus.extmemaddress, bus.extmemdata, want);
         end
         model_step(rdv);
         n_vec++;
         if (bus.rdval !== exp_rd[i]) begin
            n_err++;
            $display("FAIL dir_rdval[%0d]: got %h, want %h", i, bus.rdval, exp_rd[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [31:0] rdv, pc_exp;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 256; i++) prog[i] = rand_instr();
         load_prog();
         apply_reset(2);
         for (int c = 0; c < 300; c++) begin
            bus.swval         = 5'($urandom);
            bus.extmemaddress = 9'($urandom);
            #1;
            pc_exp = m_pc;
            n_vec++;
            if (dut.pc !== pc_exp) begin
               n_err++;
               $display("FAIL rnd_pc p%0d c%0d: got %h, want %h", p, c, dut.pc, pc_exp);
            end
            n_vec++;
            if (bus.extmemdata !== m_mem[bus.extmemaddress]) begin
               n_err++;
               $display("FAIL rnd_dmem p%0d c%0d: got %h, want %h", p, c, bus.extmemdata, m_mem[bus.extmemaddress]);
            end
            model_step(rdv);
            n_vec++;
            if (bus.rdval !== rdv) begin
               n_err++;
               $display("FAIL rnd_rdval p%0d c%0d pc %h: got %h, want %h", p, c, pc_exp, bus.rdval, rdv);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rdv;
      for (int i = 0; i < 256; i++) prog[i] = rand_instr();
      load_prog();
      apply_reset(2);
      for (int c = 0; c < 60; c++) begin
         bus.swval = 5'($urandom);
         if (c == 40) begin
            reset = 1'b1;
            #1;
            n_vec++;
            if (bus.rdval !== 32'd0) begin
               n_err++;
               $display("FAIL mid_reset_rdval: got %h, want 00000000", bus.rdval);
            end
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               bus.extmemaddress = 9'($urandom);
               #1;
               if (k == 0) begin
                  n_vec++;
                  if (dut.pc !== 32'd0) begin
                     n_err++;
                     $display("FAIL mid_reset_pc: got %h, want 00000000", dut.pc);
                  end
               end
               n_vec++;
               if (bus.extmemdata !== m_mem[bus.extmemaddress]) begin
                  n_err++;
                  $display("FAIL mid_reset_dmem[%0d]: got %h, want %h", bus.extmemaddress, bus.extmemdata, m_mem[bus.extmemaddress]);
               end
            end
            @(negedge clk);
            reset = 1'b0;
            m_pc  = 32'd0;
            for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
         end
         #1;
         n_vec++;
         if (dut.pc !== m_pc) begin
            n_err++;
            $display("FAIL mid_pc c%0d: got %h, want %h", c, dut.pc, m_pc);
         end
         model_step(rdv);
         n_vec++;
         if (bus.rdval !== rdv) begin
            n_err++;
            $display("FAIL mid_rdval c%0d: got %h, want %h", c, bus.rdval, rdv);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] v;
      bus.swval         = 5'd0;
      bus.extmemaddress = 9'd0;
      for (int i = 0; i < 512; i++) begin
         v            = $urandom;
         m_mem[i]     = v;
         dut.dmem[i] <= v;
      end
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_pc = 32'd0;
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
